// File: rtl/coriolis_pkg.sv
// coriolis_pkg: shared widths, FlopoCo exception code, divider latency and clog2 helper
package coriolis_pkg;
  localparam int STREAMW = 34;
  localparam logic [1:0] FPC_EXC_NORMAL = 2'b01;
  localparam int FPDIV_LATENCY = 13;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/coriolis_rr_arb.sv
// coriolis_rr_arb: round-robin grant over req, search starts at ptr, ptr moves past winner when enabled
module coriolis_rr_arb
  import coriolis_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = NREQ > 1 ? clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_vld
);
  logic [IW-1:0] ptr;
  logic          hit;
  int            k;
  // first asserted request at or after ptr, wrapping
  always_comb begin
    hit = 1'b0;
    gnt_idx = '0;
    k = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!hit && req[k]) begin
        hit = 1'b1;
        gnt_idx = IW'(k);
      end
    end
    gnt_vld = hit & en;
    gnt = gnt_vld ? NREQ'(1) << gnt_idx : '0;
  end
  // pointer moves just past the winner; held on a frozen pipe
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (gnt_vld) ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end
endmodule

// File: rtl/coriolis_fpdiv_arb.sv
// coriolis_fpdiv_arb: shares one pipelined FP divider among NREQ streams (optional CORIOLIS_DIVARB_STATS_EN counters)
module coriolis_fpdiv_arb #(
  parameter int STREAMW = coriolis_pkg::STREAMW,
  parameter int NREQ    = 4,
  parameter int LATENCY = coriolis_pkg::FPDIV_LATENCY,
  parameter int TAGW    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*STREAMW-1:0] req_x,
  input  logic [NREQ*STREAMW-1:0] req_y,
  output logic [NREQ-1:0]         res_valid,
  input  logic [NREQ-1:0]         res_ready,
  output logic [STREAMW-1:0]      res_data,
  output logic [STREAMW-1:0]      div_x,
  output logic [STREAMW-1:0]      div_y,
  output logic                    div_stall,
  input  logic [STREAMW-1:0]      div_r
`ifdef CORIOLIS_DIVARB_STATS_EN
  ,
  output logic [31:0]             stat_issued,
  output logic [31:0]             stat_stall
`endif
);
  import coriolis_pkg::*;
  localparam int IW = NREQ > 1 ? clog2(NREQ) : 1;
  logic [LATENCY:0]    vld;
  logic [TAGW-1:0]     tag [LATENCY+1];
  logic [2**TAGW-1:0]  rr_ext;
  logic                advance;
  logic [NREQ-1:0]     gnt;
  logic [IW-1:0]       gnt_idx;
  logic                gnt_vld;
  // widen res_ready so any tag value indexes safely
  always_comb begin
    rr_ext = '0;
    rr_ext[NREQ-1:0] = res_ready;
  end
  assign advance   = ~(vld[LATENCY] & ~rr_ext[tag[LATENCY]]);
  assign div_stall = ~advance & ~rst;
  assign res_valid = (vld[LATENCY] & ~rst) ? NREQ'(1) << tag[LATENCY] : '0;
  assign res_data  = div_r;
  assign req_ready = gnt;
  coriolis_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (advance & ~rst),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );
  // tag/valid tracker shadows the divider pipe; whole pipe freezes with the divider
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i <= LATENCY; i++) tag[i] <= '0;
      div_x <= '0;
      div_y <= '0;
    end else if (advance) begin
      vld <= {vld[LATENCY-1:0], gnt_vld};
      for (int i = 1; i <= LATENCY; i++) tag[i] <= tag[i-1];
      if (gnt_vld) begin
        tag[0] <= TAGW'(gnt_idx);
        div_x  <= req_x[int'(gnt_idx)*STREAMW +: STREAMW];
        div_y  <= req_y[int'(gnt_idx)*STREAMW +: STREAMW];
      end
    end
  end
`ifdef CORIOLIS_DIVARB_STATS_EN
  // saturating issue and stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (gnt_vld && !(&stat_issued)) stat_issued <= stat_issued + 32'd1;
      if (div_stall && !(&stat_stall)) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_coriolis_fpdiv_arb.sv
// tb_coriolis_fpdiv_arb: directed bench with a behavioural stallable divider model (CORIOLIS_DIVARB_STATS_EN adds counter checks)
module tb_coriolis_fpdiv_arb;
  localparam int W = 34;
  localparam int N = 4;
  localparam int L = 13;
  localparam logic [W-1:0] ONE  = 34'h13f800000;
  localparam logic [W-1:0] TWO  = 34'h140000000;
  localparam logic [W-1:0] HALF = 34'h13f000000;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]   req_valid, req_ready, res_valid, res_ready;
  logic [N*W-1:0] req_x, req_y;
  logic [W-1:0]   res_data, div_x, div_y, div_r;
  logic           div_stall;
`ifdef CORIOLIS_DIVARB_STATS_EN
  logic [31:0]    stat_issued, stat_stall;
`endif
  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int rx_idx[$], rx_cyc[$], ex_idx[$];
  logic [W-1:0] rx_dat[$], ex_dat[$];
  logic [W-1:0] dp [L];

  coriolis_fpdiv_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .div_x     (div_x),
    .div_y     (div_y),
    .div_stall (div_stall),
    .div_r     (div_r)
`ifdef CORIOLIS_DIVARB_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] fdiv(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x == ONE && y == TWO) ? HALF : x ^ y;
  endfunction
  function automatic logic [W-1:0] xv(input int i, input int k);
    return 34'h100000000 + W'(k << 8) + W'(i);
  endfunction
  function automatic logic [W-1:0] yv(input int i);
    return 34'h140000000 + W'(i << 12);
  endfunction
  function automatic logic [63:0] oh(input int n);
    return 64'(1) << n;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!div_stall) begin
      dp[0] <= fdiv(div_x, div_y);
      for (int i = 1; i < L; i++) dp[i] <= dp[i-1];
    end
  end
  assign div_r = dp[L-1];

  always @(negedge clk)
    if (!rst)
      for (int i = 0; i < N; i++)
        if (res_valid[i] && res_ready[i]) begin
          rx_idx.push_back(i);
          rx_dat.push_back(res_data);
          rx_cyc.push_back(cyc);
        end

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int k);
    for (int i = 0; i < N; i++) begin
      req_x[i*W +: W] = xv(i, k);
      req_y[i*W +: W] = yv(i);
    end
  endtask

  task automatic expect_rx(input int i, input int k);
    ex_idx.push_back(i);
    ex_dat.push_back(fdiv(xv(i, k), yv(i)));
  endtask

  task automatic rx_cmp(input string nm);
    chk({nm, "_cnt"}, 64'(rx_idx.size()), 64'(ex_idx.size()));
    for (int i = 0; i < ex_idx.size() && i < rx_idx.size(); i++) begin
      chk({nm, "_idx"}, 64'(rx_idx[i]), 64'(ex_idx[i]));
      chk({nm, "_dat"}, 64'(rx_dat[i]), 64'(ex_dat[i]));
    end
    rx_idx.delete(); rx_dat.delete(); rx_cyc.delete();
    ex_idx.delete(); ex_dat.delete();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '1;
    res_ready = '1;
    req_x = '0;
    req_y = '0;
    tick;
    tick;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_div_stall", 64'(div_stall), 64'(0));
    tick;
    rst = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_div_x", 64'(div_x), 64'(0));
    chk("rst_div_y", 64'(div_y), 64'(0));
    chk("idle_res_valid", 64'(res_valid), 64'(0));
    for (int k = 0; k < 8; k++) begin
      set_ops(k);
      req_valid = '1;
      #1;
      chk("fair_grant", 64'(req_ready), oh(k % 4));
      expect_rx(k % 4, k);
      tick;
    end
    req_valid = '0;
    repeat (16) tick;
    for (int i = 1; i < rx_cyc.size(); i++) chk("fair_b2b", 64'(rx_cyc[i] - rx_cyc[i-1]), 64'(1));
    rx_cmp("fair");
    req_x = '0;
    req_y = '0;
    req_x[0 +: W] = ONE;
    req_y[0 +: W] = TWO;
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 64'(req_ready), 64'(4'b0001));
    ex_idx.push_back(0);
    ex_dat.push_back(HALF);
    tick;
    req_valid = '0;
    #1;
    chk("single_div_x", 64'(div_x), 64'(ONE));
    chk("single_div_y", 64'(div_y), 64'(TWO));
    for (int i = 1; i <= L; i++) begin
      chk("single_quiet", 64'(res_valid), 64'(0));
      tick;
    end
    chk("single_res_valid", 64'(res_valid), 64'(4'b0001));
    chk("single_res_data", 64'(res_data), 64'(HALF));
    tick;
    chk("single_after", 64'(res_valid), 64'(0));
    set_ops(20);
    req_valid = 4'b1000;
    #1;
    chk("ptr_only3", 64'(req_ready), 64'(4'b1000));
    expect_rx(3, 20);
    tick;
    req_valid = 4'b1001;
    #1;
    chk("ptr_wrap0", 64'(req_ready), 64'(4'b0001));
    expect_rx(0, 20);
    tick;
    req_valid = '0;
    repeat (16) tick;
    rx_cmp("ptr");
    set_ops(30);
    res_ready = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      req_valid = '1;
      #1;
      chk("bp_grant", 64'(req_ready), oh((k + 1) % 4));
      expect_rx((k + 1) % 4, 30);
      tick;
    end
    req_valid = '0;
    repeat (11) tick;
    req_valid = '1;
    #1;
    for (int s = 0; s < 5; s++) begin
      chk("bp_stall", 64'(div_stall), 64'(1));
      chk("bp_no_issue", 64'(req_ready), 64'(0));
      chk("bp_head", 64'(res_valid), 64'(4'b0100));
      chk("bp_head_data", 64'(res_data), 64'(fdiv(xv(2, 30), yv(2))));
      tick;
    end
    req_valid = '0;
    res_ready = '1;
    #1;
    chk("bp_release", 64'(div_stall), 64'(0));
    repeat (16) tick;
    rx_cmp("bp");
    set_ops(40);
    for (int k = 0; k < 6; k++) begin
      req_valid = '1;
      #1;
      chk("mid_grant", 64'(req_ready), oh((k + 1) % 4));
      tick;
    end
    req_valid = '0;
    repeat (2) tick;
    rst = 1'b1;
    req_valid = '1;
    #1;
    chk("mid_rst_ready", 64'(req_ready), 64'(0));
    chk("mid_rst_valid", 64'(res_valid), 64'(0));
    chk("mid_rst_stall", 64'(div_stall), 64'(0));
    tick;
    rst = 1'b0;
    req_valid = '0;
    for (int i = 0; i <= L; i++) begin
      #1;
      chk("mid_discard", 64'(res_valid), 64'(0));
      tick;
    end
    chk("mid_rx_empty", 64'(rx_idx.size()), 64'(0));
    req_valid = 4'b1010;
    #1;
    chk("mid_ptr0", 64'(req_ready), 64'(4'b0010));
    expect_rx(1, 40);
    tick;
    req_valid = '0;
    repeat (16) tick;
    rx_cmp("mid");
`ifdef CORIOLIS_DIVARB_STATS_EN
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("stat_issued_clr", 64'(stat_issued), 64'(0));
    chk("stat_stall_clr", 64'(stat_stall), 64'(0));
    set_ops(50);
    req_valid = '1;
    repeat (10) tick;
    req_valid = '0;
    repeat (4) tick;
    res_ready = '0;
    repeat (3) tick;
    res_ready = '1;
    repeat (16) tick;
    chk("stat_issued", 64'(stat_issued), 64'(10));
    chk("stat_stall", 64'(stat_stall), 64'(3));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("stat_issued_rst", 64'(stat_issued), 64'(0));
    chk("stat_stall_rst", 64'(stat_stall), 64'(0));
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
